id_ex_stage: RTL



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, control bundle and ALU opcodes for the 16-bit, 16-register pipeline.
// ctrl_t is {regwrite, memread, memwrite, memtoreg, alusrc, halt, aluop}: six flags plus aluop.
package cpu_pkg;
   localparam int DATA_W  = 16;
   localparam int REG_AW  = 4;
   localparam int ALUOP_W = 4;

   typedef struct packed {
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               memtoreg;
      logic               alusrc;
      logic               halt;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   localparam ctrl_t BUBBLE_CTRL = '0;

   localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd5;
   localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd6;
   localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd7;
   localparam logic [ALUOP_W-1:0] ALU_PASS = 4'd8;
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the
// instruction in ID. Also used by the PC and IF/ID enable logic.
module hazard_detect #(
   parameter int REG_AW = cpu_pkg::REG_AW
) (
   input  logic              flush,
   input  logic              hold,
   input  logic              ex_valid,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_regdest,
   input  logic              id_valid,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_regrs,
   input  logic [REG_AW-1:0] id_regrt,
   output logic              load_use,
   output logic              stall
);
   logic rs_match;
   logic rt_match;

   assign rs_match = id_uses_rs && (id_regrs == ex_regdest);
   assign rt_match = id_uses_rt && (id_regrt == ex_regdest);

   // r0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = ex_valid && ex_memread && (ex_regdest != '0) && id_valid
                     && (rs_match || rt_match);
   assign stall    = load_use && !flush && !hold;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, flush and hold.
module id_ex_stage import cpu_pkg::*; #(
   parameter int DATA_W  = cpu_pkg::DATA_W,
   parameter int REG_AW  = cpu_pkg::REG_AW,
   parameter int ALUOP_W = cpu_pkg::ALUOP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              hold,
   input  logic              if_id_valid,
   input  logic [REG_AW-1:0] if_id_regrs,
   input  logic [REG_AW-1:0] if_id_regrt,
   input  logic [REG_AW-1:0] if_id_regdest,
   input  logic              if_id_uses_rs,
   input  logic              if_id_uses_rt,
   input  logic [DATA_W-1:0] if_id_rs_data,
   input  logic [DATA_W-1:0] if_id_rt_data,
   input  logic [DATA_W-1:0] if_id_imm,
   input  logic [DATA_W-1:0] if_id_pc_plus2,
   input  ctrl_t             if_id_ctrl,
   output logic              stall,
   output logic              id_ex_valid,
   output logic [REG_AW-1:0] id_ex_regrs,
   output logic [REG_AW-1:0] id_ex_regrt,
   output logic [REG_AW-1:0] id_ex_regdest,
   output logic [DATA_W-1:0] id_ex_rs_data,
   output logic [DATA_W-1:0] id_ex_rt_data,
   output logic [DATA_W-1:0] id_ex_imm,
   output logic [DATA_W-1:0] id_ex_pc_plus2,
   output ctrl_t             id_ex_ctrl
);
   logic              load_use;
   logic              load_bubble;
   logic              valid_reg;
   logic [REG_AW-1:0] regrs_reg, regrt_reg, regdest_reg;
   logic [DATA_W-1:0] rs_data_reg, rt_data_reg, imm_reg, pc_plus2_reg;
   ctrl_t             ctrl_reg;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .flush      (flush),
      .hold       (hold),
      .ex_valid   (valid_reg),
      .ex_memread (ctrl_reg.memread),
      .ex_regdest (regdest_reg),
      .id_valid   (if_id_valid),
      .id_uses_rs (if_id_uses_rs),
      .id_uses_rt (if_id_uses_rt),
      .id_regrs   (if_id_regrs),
      .id_regrt   (if_id_regrt),
      .load_use   (load_use),
      .stall      (stall)
   );

   // flush outranks hold so a redirect is never lost; hold outranks the stall bubble
   assign load_bubble = !rst_n || flush || (!hold && (load_use || !if_id_valid));

   always_ff @(posedge clk) begin
      if (load_bubble) begin
         valid_reg    <= 1'b0;
         regrs_reg    <= '0;
         regrt_reg    <= '0;
         regdest_reg  <= '0;
         rs_data_reg  <= '0;
         rt_data_reg  <= '0;
         imm_reg      <= '0;
         pc_plus2_reg <= '0;
         ctrl_reg     <= BUBBLE_CTRL;
      end else if (!hold) begin
         valid_reg    <= 1'b1;
         regrs_reg    <= if_id_regrs;
         regrt_reg    <= if_id_regrt;
         regdest_reg  <= if_id_regdest;
         rs_data_reg  <= if_id_rs_data;
         rt_data_reg  <= if_id_rt_data;
         imm_reg      <= if_id_imm;
         pc_plus2_reg <= if_id_pc_plus2;
         ctrl_reg     <= if_id_ctrl;
      end
   end

   assign id_ex_valid    = valid_reg;
   assign id_ex_regrs    = regrs_reg;
   assign id_ex_regrt    = regrt_reg;
   assign id_ex_regdest  = regdest_reg;
   assign id_ex_rs_data  = rs_data_reg;
   assign id_ex_rt_data  = rt_data_reg;
   assign id_ex_imm      = imm_reg;
   assign id_ex_pc_plus2 = pc_plus2_reg;
   assign id_ex_ctrl     = ctrl_reg;
endmodule
